gray_2_binary_receiver: RTL and testbench

Registered Gray-to-binary receiver for a Gray-coded count produced elsewhere in the design, for example an asynchronous FIFO pointer or a position counter.
- Samples `gray_in` through a configurable flop synchronizer, decodes it to binary and registers the result.
- Reports the binary increment since the previous accepted sample.
- Flags any sample whose Gray code changed by more than one bit, which is a legal-step violation.
- Sits at the consuming end of a Gray-coded count path.

---
 rtl/gray_2_binary_receiver.sv | 69 ++++++
 tb/tb_gray_2_binary_receiver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_2_binary_receiver.sv
// Receives a Gray-coded count from another part of the design, synchronizes it and decodes it to binary.
// It registers the decoded value, its increment since the last accepted sample, and a flag for illegal multi-bit steps.
module gray_2_binary_receiver #(
  parameter int IN_DATA_WIDTH = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IN_DATA_WIDTH-1:0] gray_in,
  input  logic                     enable,
  output logic [IN_DATA_WIDTH-1:0] binary_out,
  output logic [IN_DATA_WIDTH-1:0] delta_out,
  output logic                     binary_valid,
  output logic                     step_error
);

  // Handshake: enable acts as a valid with no ready. A high enable on an edge always accepts
  // the synchronized sample. binary_valid is then a one-cycle valid for binary_out/delta_out,
  // and nothing can back-pressure it.

  logic [IN_DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [IN_DATA_WIDTH-1:0] gray_s;
  logic [IN_DATA_WIDTH-1:0] bin_d;
  logic [IN_DATA_WIDTH-1:0] prev_gray;
  logic [IN_DATA_WIDTH-1:0] gray_diff;
  logic                     multi_bit;

  // The synchronizer shifts every cycle so gray_s stays fresh while enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gray_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    bin_d = '0;
    bin_d[IN_DATA_WIDTH-1] = gray_s[IN_DATA_WIDTH-1];
    for (int i = IN_DATA_WIDTH - 2; i >= 0; i--) bin_d[i] = bin_d[i+1] ^ gray_s[i];
  end

  // Clearing the lowest set bit leaves something only when two or more bits differ.
  assign gray_diff = gray_s ^ prev_gray;
  assign multi_bit = (gray_diff & (gray_diff - IN_DATA_WIDTH'(1))) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray    <= '0;
      binary_out   <= '0;
      delta_out    <= '0;
      binary_valid <= 1'b0;
      step_error   <= 1'b0;
    end else if (enable) begin
      prev_gray    <= gray_s;
      binary_out   <= bin_d;
      delta_out    <= bin_d - binary_out;
      binary_valid <= 1'b1;
      step_error   <= multi_bit;
    end else begin
      binary_valid <= 1'b0;
      step_error   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_2_binary_receiver.sv
// Bench for gray_2_binary_receiver: directed vector table, reset sequences and a randomized run
// compared against a behavioural model of the receiver.
module tb_gray_2_binary_receiver;
  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic         enable = 1'b0;
  logic [W-1:0] binary_out;
  logic [W-1:0] delta_out;
  logic         binary_valid;
  logic         step_error;

  gray_2_binary_receiver #(.IN_DATA_WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .enable(enable),
    .binary_out(binary_out), .delta_out(delta_out),
    .binary_valid(binary_valid), .step_error(step_error)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] gray;
    logic         en;
    int           hold;
    logic [W-1:0] bin;
    logic [W-1:0] delta;
    logic         valid;
    logic         err;
  } vec_t;

  vec_t vecs[$];

  // scoreboard model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_prev;
  logic [W-1:0] m_bin;
  logic [W-1:0] m_delta;
  logic         m_valid;
  logic         m_err;

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Decoding searches for the binary value whose Gray code matches.
  function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
    for (int b = 0; b < (1 << W); b++) begin
      logic [W-1:0] bb;
      bb = W'(b);
      if (to_gray(bb) == g) return bb;
    end
    return '0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] b, input logic [W-1:0] d,
                            input logic v, input logic e);
    check({tag, ".binary_out"}, 32'(binary_out), 32'(b));
    check({tag, ".delta_out"}, 32'(delta_out), 32'(d));
    check({tag, ".binary_valid"}, 32'(binary_valid), 32'(v));
    check({tag, ".step_error"}, 32'(step_error), 32'(e));
  endtask

  // driver tasks
  task automatic step(input logic [W-1:0] g, input logic en);
    @(negedge clk);
    gray_in = g;
    enable  = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    enable  = 1'b0;
    gray_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_edge(input logic [W-1:0] g, input logic en);
    logic [W-1:0] gs;
    logic [W-1:0] nb;
    gs = exp_q[0];
    if (en) begin
      nb      = from_gray(gs);
      m_delta = nb - m_bin;
      m_bin   = nb;
      m_err   = $countones(gs ^ m_prev) > 1;
      m_prev  = gs;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
      m_err   = 1'b0;
    end
    void'(exp_q.pop_front());
    exp_q.push_back(g);
  endtask

  initial begin
    logic [W-1:0] cur_bin;
    logic [W-1:0] g;
    logic         en;

    vecs.push_back('{4'b0111, 1'b1, 3, 4'd5,  4'd5,  1'b1, 1'b1});
    vecs.push_back('{4'b0101, 1'b1, 3, 4'd6,  4'd1,  1'b1, 1'b0});
    vecs.push_back('{4'b1001, 1'b1, 3, 4'd14, 4'd8,  1'b1, 1'b1});
    vecs.push_back('{4'b1000, 1'b1, 3, 4'd15, 4'd1,  1'b1, 1'b0});
    vecs.push_back('{4'b0000, 1'b1, 3, 4'd0,  4'd1,  1'b1, 1'b0});
    vecs.push_back('{4'b1111, 1'b1, 3, 4'd10, 4'd10, 1'b1, 1'b1});
    vecs.push_back('{4'b1111, 1'b1, 1, 4'd10, 4'd0,  1'b1, 1'b0});
    vecs.push_back('{4'b0000, 1'b1, 3, 4'd0,  4'd6,  1'b1, 1'b1});
    vecs.push_back('{4'b0001, 1'b0, 3, 4'd0,  4'd6,  1'b0, 1'b0});
    vecs.push_back('{4'b0011, 1'b0, 3, 4'd0,  4'd6,  1'b0, 1'b0});
    vecs.push_back('{4'b0011, 1'b1, 1, 4'd2,  4'd2,  1'b1, 1'b1});
    vecs.push_back('{4'b0011, 1'b1, 1, 4'd2,  4'd0,  1'b1, 1'b0});
    vecs.push_back('{4'b1101, 1'b1, 3, 4'd9,  4'd7,  1'b1, 1'b1});

    do_reset();
    #1;
    check_outs("reset", '0, '0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      for (int h = 0; h < vecs[i].hold; h++) begin
        step(vecs[i].gray, vecs[i].en);
        if (!vecs[i].en) begin
          check($sformatf("vec%0d.idle_valid", i), 32'(binary_valid), 32'd0);
        end
      end
      check_outs($sformatf("vec%0d", i), vecs[i].bin, vecs[i].delta, vecs[i].valid, vecs[i].err);
    end

    // Mid-operation reset: outputs clear before any clock edge, and stay quiet while gray_in toggles.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(W'($urandom_range(0, 15)), 1'b1);
      check_outs($sformatf("in_reset%0d", i), '0, '0, 1'b0, 1'b0);
    end
    @(negedge clk);
    gray_in = 4'b0001;
    enable  = 1'b0;
    rst_n   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, 1'b0);
      check_outs($sformatf("release%0d", i), '0, '0, 1'b0, 1'b0);
    end
    step(4'b0001, 1'b1);
    check_outs("after_reset", 4'd1, 4'd1, 1'b1, 1'b0);

    // Randomized run against the model.
    do_reset();
    exp_q.delete();
    for (int i = 0; i < S; i++) exp_q.push_back('0);
    m_prev = '0; m_bin = '0; m_delta = '0; m_valid = 1'b0; m_err = 1'b0;
    cur_bin = '0;
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: cur_bin = cur_bin + 1'b1;
        6:                cur_bin = cur_bin - 1'b1;
        7:                cur_bin = cur_bin;
        default:          cur_bin = W'($urandom_range(0, 15));
      endcase
      g  = to_gray(cur_bin);
      en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      gray_in = g;
      enable  = en;
      @(posedge clk);
      model_edge(g, en);
      #1;
      check_outs("rand", m_bin, m_delta, m_valid, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
